// File: rtl/sa_feeder_if.sv
// Handshake and data bundle between a systolic-array feeder and its producer.
// Signal names keep the feeder's i_/o_ view, so inputs to the feeder start with i_.
interface sa_feeder_if #(
    parameter int ROWS = 9,
    parameter int COLS = 1
);
    logic                   i_start;
    logic                   i_w_valid;
    logic [COLS*8-1:0]      i_w_data;
    logic                   o_w_ready;
    logic                   i_a_valid;
    logic                   i_a_last;
    logic [ROWS*8-1:0]      i_a_data;
    logic                   o_a_ready;
    logic [ROWS*9-1:0]      o_west_data;
    logic [COLS*32-1:0]     o_north_data;
    logic                   o_busy;
    logic                   o_done;

    modport slave (
        input  i_start, i_w_valid, i_w_data, i_a_valid, i_a_last, i_a_data,
        output o_w_ready, o_a_ready, o_west_data, o_north_data, o_busy, o_done
    );

    modport master (
        output i_start, i_w_valid, i_w_data, i_a_valid, i_a_last, i_a_data,
        input  o_w_ready, o_a_ready, o_west_data, o_north_data, o_busy, o_done
    );
endinterface

// File: rtl/sa_feeder.sv
// Systolic-array feeder: shifts weights down the north columns, then streams
// activations into the west rows through a diagonal skew of per-row delay lines.
module sa_feeder #(
    parameter int ROWS = 9,
    parameter int COLS = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    sa_feeder_if.slave  bus
);
    localparam int CW = $clog2(ROWS + 1);
    localparam logic [CW-1:0] LP_LAST_ROW   = CW'(ROWS - 1);
    localparam logic [CW-1:0] LP_LAST_FLUSH = CW'((ROWS > 1) ? ROWS - 2 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WLOAD,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cntNext;
    logic               w_wReady;
    logic               w_aReady;
    logic               w_wAccept;
    logic               w_aAccept;
    logic [COLS*32-1:0] w_northNext;
    logic [COLS*32-1:0] r_north;
    logic [ROWS*9-1:0]  w_west;

    assign w_wReady  = (r_state == ST_WLOAD);
    assign w_aReady  = (r_state == ST_STREAM);
    assign w_wAccept = bus.i_w_valid && w_wReady;
    assign w_aAccept = bus.i_a_valid && w_aReady;

    assign bus.o_w_ready    = w_wReady;
    assign bus.o_a_ready    = w_aReady;
    assign bus.o_busy       = (r_state != ST_IDLE);
    assign bus.o_done       = (r_state == ST_DONE);
    assign bus.o_north_data = r_north;
    assign bus.o_west_data  = w_west;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_stateNext = ST_WLOAD;
                    w_cntNext   = '0;
                end
            end
            ST_WLOAD: begin
                if (w_wAccept) begin
                    if (r_cnt == LP_LAST_ROW) begin
                        w_stateNext = ST_STREAM;
                        w_cntNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + CW'(1);
                    end
                end
            end
            ST_STREAM: begin
                if (w_aAccept && bus.i_a_last) begin
                    w_stateNext = (ROWS > 1) ? ST_FLUSH : ST_DONE;
                    w_cntNext   = '0;
                end
            end
            // Flush lasts ROWS-1 cycles so DONE lines up with the last element on the bottom row.
            ST_FLUSH: begin
                if (r_cnt == LP_LAST_FLUSH) begin
                    w_stateNext = ST_DONE;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + CW'(1);
                end
            end
            ST_DONE: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    // Weights pass straight through in arrival order; the array's shift-down places the first one on the bottom row.
    always_comb begin
        w_northNext = '0;
        if (w_wAccept) begin
            for (int c = 0; c < COLS; c++) begin
                w_northNext[(COLS-c)*32-1 -: 32] = {24'd0, bus.i_w_data[(COLS-c)*8-1 -: 8]};
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_north <= '0;
        end else begin
            r_north <= w_northNext;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [8:0] r_line [0:r];
        logic [8:0] w_in;

        assign w_in = w_aAccept ? {1'b1, bus.i_a_data[(ROWS-r)*8-1 -: 8]} : 9'd0;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                for (int k = 0; k <= r; k++) begin
                    r_line[k] <= '0;
                end
            end else begin
                r_line[0] <= w_in;
                for (int k = 1; k <= r; k++) begin
                    r_line[k] <= r_line[k-1];
                end
            end
        end

        assign w_west[(ROWS-r)*9-1 -: 9] = r_line[r];
    end
endmodule
